cpu_sequencer: RTL and testbench

CPU_SEQUENCER -- requirements
Module: cpu_sequencer

---
 rtl/cpu_sequencer_pkg.sv | 43 ++++
 rtl/cpu_sequencer.sv | 139 +++++++++++++
 tb/tb_cpu_sequencer.sv | 339 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_sequencer_pkg.sv
// Shared encodings for the multi-cycle RV32I control sequencer.
package riscv_defines;

    typedef logic [6:0] opcode_t;

    localparam opcode_t OP_LUI    = 7'b0110111;
    localparam opcode_t OP_AUIPC  = 7'b0010111;
    localparam opcode_t OP_JAL    = 7'b1101111;
    localparam opcode_t OP_JALR   = 7'b1100111;
    localparam opcode_t OP_BRANCH = 7'b1100011;
    localparam opcode_t OP_LOAD   = 7'b0000011;
    localparam opcode_t OP_STORE  = 7'b0100011;
    localparam opcode_t OP_I_TYPE = 7'b0010011;
    localparam opcode_t OP_R_TYPE = 7'b0110011;
    localparam opcode_t OP_FENCE  = 7'b0001111;
    localparam opcode_t OP_SYSTEM = 7'b1110011;

    // FETCH/DECODE/EXECUTE keep their legacy codes; later states extend the set.
    typedef logic [2:0] state_t;

    localparam state_t FETCH     = 3'd0;
    localparam state_t DECODE    = 3'd1;
    localparam state_t EXECUTE   = 3'd2;
    localparam state_t MEMORY    = 3'd3;
    localparam state_t WRITEBACK = 3'd4;
    localparam state_t HALT      = 3'd5;
    localparam state_t TRAP      = 3'd6;

    typedef logic [1:0] pc_sel_t;

    localparam pc_sel_t PC_PLUS4  = 2'd0;
    localparam pc_sel_t PC_TARGET = 2'd1;

    typedef logic [1:0] trap_t;

    localparam trap_t TRAP_NONE    = 2'd0;
    localparam trap_t TRAP_ILLEGAL = 2'd1;
    localparam trap_t TRAP_IMEM_TO = 2'd2;
    localparam trap_t TRAP_DMEM_TO = 2'd3;

    localparam logic [7:0] WAIT_TIMEOUT = 8'd255;

endpackage

// File: rtl/cpu_sequencer.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK
// with absorbing HALT and TRAP states, memory wait timeouts and a retired
// instruction counter.
module cpu_sequencer
    import riscv_defines::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  opcode,
    input  logic        imem_valid,
    input  logic        dmem_valid,
    input  logic        branch_taken,
    input  logic        halt_req,
    output logic [2:0]  current_state,
    output logic        imem_req,
    output logic        ir_we,
    output logic        target_we,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic        reg_we,
    output logic        pc_we,
    output logic [1:0]  pc_sel,
    output logic [1:0]  trap_cause,
    output logic [31:0] instret
);

    state_t      state_q, state_d;
    logic [7:0]  wait_q, wait_d;
    trap_t       trap_q, trap_d;
    logic [31:0] instret_q, instret_d;

    function automatic logic is_legal(input opcode_t op);
        case (op)
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD,
            OP_STORE, OP_I_TYPE, OP_R_TYPE, OP_FENCE, OP_SYSTEM: return 1'b1;
            default:                                             return 1'b0;
        endcase
    endfunction

    // Next-state, wait counter, trap cause and strobe decode.
    // The wait counter defaults to zero so every entry into FETCH/MEMORY starts clean.
    always_comb begin
        state_d   = state_q;
        wait_d    = '0;
        trap_d    = trap_q;
        instret_d = instret_q;
        imem_req  = 1'b0;
        ir_we     = 1'b0;
        target_we = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        reg_we    = 1'b0;
        pc_we     = 1'b0;
        pc_sel    = PC_PLUS4;
        case (state_q)
            FETCH: begin
                imem_req = 1'b1;
                if (imem_valid) begin
                    ir_we   = 1'b1;
                    state_d = DECODE;
                end else if (wait_q == WAIT_TIMEOUT) begin
                    state_d = TRAP;
                    trap_d  = TRAP_IMEM_TO;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            DECODE: begin
                if (!is_legal(opcode)) begin
                    state_d = TRAP;
                    trap_d  = TRAP_ILLEGAL;
                end else begin
                    target_we = (opcode == OP_JAL) || (opcode == OP_JALR) ||
                                (opcode == OP_BRANCH);
                    state_d   = EXECUTE;
                end
            end
            EXECUTE: begin
                if ((opcode == OP_LOAD) || (opcode == OP_STORE)) begin
                    state_d = MEMORY;
                end else begin
                    state_d = WRITEBACK;
                end
            end
            MEMORY: begin
                dmem_req = 1'b1;
                dmem_we  = (opcode == OP_STORE);
                if (dmem_valid) begin
                    state_d = WRITEBACK;
                end else if (wait_q == WAIT_TIMEOUT) begin
                    state_d = TRAP;
                    trap_d  = TRAP_DMEM_TO;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            WRITEBACK: begin
                pc_we  = 1'b1;
                case (opcode)
                    OP_R_TYPE, OP_I_TYPE, OP_LOAD, OP_LUI, OP_AUIPC,
                    OP_JAL, OP_JALR: reg_we = 1'b1;
                    default:         reg_we = 1'b0;
                endcase
                if ((opcode == OP_JAL) || (opcode == OP_JALR) ||
                    ((opcode == OP_BRANCH) && branch_taken)) begin
                    pc_sel = PC_TARGET;
                end
                instret_d = instret_q + 32'd1;
                state_d   = halt_req ? HALT : FETCH;
            end
            HALT, TRAP: begin
                state_d = state_q;
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    // Registered state with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= FETCH;
            wait_q    <= '0;
            trap_q    <= TRAP_NONE;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            trap_q    <= trap_d;
            instret_q <= instret_d;
        end
    end

    assign current_state = state_q;
    assign trap_cause    = trap_q;
    assign instret       = instret_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench for cpu_sequencer: a driver issues instructions and pushes
// the predicted per-instruction outcome; a negedge monitor accumulates the
// observed strobes and compares them when a retire or trap event appears.
module tb_cpu_sequencer;

    // Spec-level opcode values, kept independent of the design package.
    localparam logic [6:0] T_LUI    = 7'b0110111;
    localparam logic [6:0] T_AUIPC  = 7'b0010111;
    localparam logic [6:0] T_JAL    = 7'b1101111;
    localparam logic [6:0] T_JALR   = 7'b1100111;
    localparam logic [6:0] T_BRANCH = 7'b1100011;
    localparam logic [6:0] T_LOAD   = 7'b0000011;
    localparam logic [6:0] T_STORE  = 7'b0100011;
    localparam logic [6:0] T_ITYPE  = 7'b0010011;
    localparam logic [6:0] T_RTYPE  = 7'b0110011;
    localparam logic [6:0] T_FENCE  = 7'b0001111;
    localparam logic [6:0] T_SYSTEM = 7'b1110011;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [6:0]  opcode = '0;
    logic        imem_valid = 1'b0;
    logic        dmem_valid = 1'b0;
    logic        branch_taken = 1'b0;
    logic        halt_req = 1'b0;
    logic [2:0]  current_state;
    logic        imem_req, ir_we, target_we, dmem_req, dmem_we, reg_we, pc_we;
    logic [1:0]  pc_sel, trap_cause;
    logic [31:0] instret;

    cpu_sequencer dut (
        .clk(clk), .rst(rst), .opcode(opcode), .imem_valid(imem_valid),
        .dmem_valid(dmem_valid), .branch_taken(branch_taken), .halt_req(halt_req),
        .current_state(current_state), .imem_req(imem_req), .ir_we(ir_we),
        .target_we(target_we), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .reg_we(reg_we), .pc_we(pc_we), .pc_sel(pc_sel), .trap_cause(trap_cause),
        .instret(instret)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    typedef struct {
        bit          trap;
        bit [1:0]    cause;
        bit          halt;
        bit          reg_we;
        bit          pc_sel;
        int unsigned imem_cyc;
        int unsigned dmem_cyc;
        bit          dmem_we;
        int unsigned tgt;
        int unsigned ir;
        logic [31:0] instret_before;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model_instret = '0;

    logic [6:0] legal_ops[11] = '{T_LUI, T_AUIPC, T_JAL, T_JALR, T_BRANCH, T_LOAD,
                                  T_STORE, T_ITYPE, T_RTYPE, T_FENCE, T_SYSTEM};
    logic [6:0] wb_ops[7]     = '{T_RTYPE, T_ITYPE, T_LOAD, T_LUI, T_AUIPC, T_JAL, T_JALR};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=event required=none", name);
    endtask

    function automatic bit is_legal_op(input logic [6:0] op);
        foreach (legal_ops[i]) if (legal_ops[i] == op) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit writes_reg(input logic [6:0] op);
        foreach (wb_ops[i]) if (wb_ops[i] == op) return 1'b1;
        return 1'b0;
    endfunction

    // Reference outcome of one instruction from the behavioural rules.
    function automatic exp_t predict(input logic [6:0] op, input int unsigned di,
                                     input int unsigned dd, input bit taken, input bit halt);
        exp_t e;
        bit   is_mem;
        e = '{default: 0};
        e.instret_before = model_instret;
        is_mem = (op == T_LOAD) || (op == T_STORE);
        if (di >= 256) begin
            e.trap = 1; e.cause = 2; e.imem_cyc = 256; e.ir = 0;
            return e;
        end
        e.imem_cyc = di + 1;
        e.ir = 1;
        if (!is_legal_op(op)) begin
            e.trap = 1; e.cause = 1;
            return e;
        end
        e.tgt = ((op == T_JAL) || (op == T_JALR) || (op == T_BRANCH)) ? 1 : 0;
        if (is_mem) begin
            e.dmem_we = (op == T_STORE);
            if (dd >= 256) begin
                e.trap = 1; e.cause = 3; e.dmem_cyc = 256;
                return e;
            end
            e.dmem_cyc = dd + 1;
        end
        e.reg_we = writes_reg(op);
        e.pc_sel = (op == T_JAL) || (op == T_JALR) || ((op == T_BRANCH) && taken);
        e.halt   = halt;
        return e;
    endfunction

    // Monitor: accumulate observed strobes, compare on retire / trap entry.
    int unsigned n_imem, n_dmem, n_dwe, n_tgt, n_ir, lat;
    logic [2:0]  prev_state = '0;
    bit          pend_valid = 0;
    logic [2:0]  pend_state = '0;

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                n_imem = 0; n_dmem = 0; n_dwe = 0; n_tgt = 0; n_ir = 0; lat = 0;
                pend_valid = 0;
                prev_state = current_state;
            end else begin
                if (pend_valid) begin
                    chk("post_wb_state", current_state, pend_state);
                    pend_valid = 0;
                end
                if (imem_req)  n_imem++;
                if (dmem_req)  n_dmem++;
                if (dmem_we)   n_dwe++;
                if (target_we) n_tgt++;
                if (ir_we) begin n_ir++; lat = 0; end else lat++;
                if (current_state == 3'd5 || current_state == 3'd6)
                    chk("absorb_strobes",
                        {imem_req, ir_we, target_we, dmem_req, dmem_we, reg_we, pc_we}, 0);
                if (pc_we) begin
                    if (sb.size() == 0) fail_now("unexpected_retire");
                    else begin
                        e = sb.pop_front();
                        chk("retire_not_trap", 0, e.trap);
                        chk("reg_we", reg_we, e.reg_we);
                        chk("pc_sel", pc_sel, e.pc_sel);
                        chk("instret_at_wb", instret, e.instret_before);
                        chk("imem_req_cycles", n_imem, e.imem_cyc);
                        chk("dmem_req_cycles", n_dmem, e.dmem_cyc);
                        chk("dmem_we_cycles", n_dwe, e.dmem_we ? e.dmem_cyc : 0);
                        chk("target_we_pulses", n_tgt, e.tgt);
                        chk("ir_we_pulses", n_ir, e.ir);
                        chk("ir_to_wb_latency", lat, 3 + e.dmem_cyc);
                        pend_valid = 1;
                        pend_state = e.halt ? 3'd5 : 3'd0;
                    end
                    n_imem = 0; n_dmem = 0; n_dwe = 0; n_tgt = 0; n_ir = 0;
                end
                if (current_state == 3'd6 && prev_state != 3'd6) begin
                    if (sb.size() == 0) fail_now("unexpected_trap");
                    else begin
                        e = sb.pop_front();
                        chk("trap_expected", 1, e.trap);
                        chk("trap_cause", trap_cause, e.cause);
                        chk("trap_imem_cycles", n_imem, e.imem_cyc);
                        chk("trap_dmem_cycles", n_dmem, e.dmem_cyc);
                        chk("trap_dmem_we_cycles", n_dwe, e.dmem_we ? e.dmem_cyc : 0);
                        chk("trap_target_we", n_tgt, e.tgt);
                        chk("trap_ir_we", n_ir, e.ir);
                    end
                end
                prev_state = current_state;
            end
        end
    end

    // Driver helpers: all input changes happen 1 time unit after a rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic bit cond(input int which);
        case (which)
            0:       return imem_req;
            1:       return dmem_req;
            2:       return imem_req || (current_state == 3'd5);
            default: return current_state == 3'd6;
        endcase
    endfunction

    task automatic poll(input int which, input string name);
        int n = 0;
        while (!cond(which)) begin
            step();
            n++;
            if (n > 400) begin
                fail_now({"timeout_", name});
                return;
            end
        end
    endtask

    task automatic run_instr(input logic [6:0] op, input int unsigned di, input int unsigned dd,
                             input bit taken, input bit halt, output bit stop);
        exp_t e;
        e = predict(op, di, dd, taken, halt);
        sb.push_back(e);
        if (!e.trap) model_instret++;
        stop = e.trap || e.halt;
        opcode = op; branch_taken = taken; halt_req = halt;
        poll(0, "fetch");
        for (int unsigned k = 0; k < di && k < 256; k++) begin
            dmem_valid = (k == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            step();
        end
        dmem_valid = 0;
        if (di >= 256) begin poll(3, "imem_trap"); return; end
        imem_valid = 1; step(); imem_valid = 0;
        if (e.trap && e.cause == 1) begin poll(3, "illegal_trap"); return; end
        if (op == T_LOAD || op == T_STORE) begin
            poll(1, "memory");
            for (int unsigned k = 0; k < dd && k < 256; k++) begin
                imem_valid = 1'($urandom_range(0, 1));
                step();
            end
            imem_valid = 0;
            if (dd >= 256) begin poll(3, "dmem_trap"); return; end
            dmem_valid = 1; step(); dmem_valid = 0;
        end
        poll(2, "retire");
    endtask

    task automatic do_reset();
        chk("sb_drained", sb.size(), 0);
        sb.delete();
        model_instret = '0;
        imem_valid = 0; dmem_valid = 0; halt_req = 0;
        rst = 1; step(); rst = 0;
        chk("rst_state", current_state, 0);
        chk("rst_imem_req", imem_req, 1);
        chk("rst_strobes", {ir_we, target_we, dmem_req, dmem_we, reg_we, pc_we}, 0);
        chk("rst_instret", instret, 0);
        chk("rst_trap_cause", trap_cause, 0);
    endtask

    task automatic idle_reset();
        repeat (3) step();
        do_reset();
    endtask

    task automatic abort_in_memory();
        opcode = T_LOAD; halt_req = 0;
        poll(0, "abort_fetch");
        imem_valid = 1; step(); imem_valid = 0;
        poll(1, "abort_mem");
        step(); step();
        rst = 1; step(); rst = 0;
        chk("abort_mem_state", current_state, 0);
        chk("abort_mem_dmem_req", dmem_req, 0);
        chk("abort_mem_imem_req", imem_req, 1);
    endtask

    task automatic abort_in_fetch();
        opcode = T_ITYPE;
        poll(0, "abort_fetch2");
        step(); step(); step();
        rst = 1; step(); rst = 0;
        chk("abort_fetch_state", current_state, 0);
        chk("abort_fetch_imem_req", imem_req, 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit          stop;
        logic [6:0]  op;
        repeat (3) step();
        do_reset();

        run_instr(T_ITYPE, 0, 0, 0, 0, stop);
        run_instr(T_LOAD, 2, 3, 0, 0, stop);
        run_instr(T_BRANCH, 1, 0, 1, 0, stop);
        run_instr(T_BRANCH, 0, 0, 0, 0, stop);
        run_instr(T_JAL, 0, 0, 0, 0, stop);
        run_instr(T_JALR, 2, 0, 0, 0, stop);
        run_instr(T_LUI, 0, 0, 1, 0, stop);
        run_instr(T_AUIPC, 1, 0, 0, 0, stop);
        run_instr(T_RTYPE, 0, 0, 0, 0, stop);
        run_instr(T_FENCE, 0, 0, 1, 0, stop);
        run_instr(T_SYSTEM, 0, 0, 0, 0, stop);
        run_instr(T_STORE, 0, 1, 0, 1, stop);
        idle_reset();

        run_instr(7'b1111111, 1, 0, 0, 0, stop);
        idle_reset();

        run_instr(T_ITYPE, 255, 0, 0, 0, stop);
        run_instr(T_ITYPE, 256, 0, 0, 0, stop);
        idle_reset();

        run_instr(T_LOAD, 0, 255, 0, 0, stop);
        run_instr(T_STORE, 0, 256, 0, 0, stop);
        idle_reset();

        abort_in_memory();
        run_instr(T_RTYPE, 3, 0, 0, 0, stop);
        abort_in_fetch();
        run_instr(T_ITYPE, 300, 0, 0, 0, stop);
        idle_reset();

        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 11) == 0) op = 7'($urandom);
            else op = legal_ops[$urandom_range(0, 10)];
            run_instr(op, $urandom_range(0, 4), $urandom_range(0, 4),
                      1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0), stop);
            if (stop) idle_reset();
        end
        idle_reset();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
